// File: rtl/hash_stream.sv
// Multi-block light hash: NB-byte blocks on a valid/ready stream, ROUNDS rounds per block, chained state.
// Optional feed-forward chaining when HASH_FEEDFWD_EN is defined.
module hash_stream #(
  parameter int NB     = 4,
  parameter int ROUNDS = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NB*8-1:0] iv,
  input  logic            msg_valid,
  output logic            msg_ready,
  input  logic [NB*8-1:0] msg_data,
  input  logic            msg_last,
  input  logic            abort,
  output logic [NB*8-1:0] digest,
  output logic            digest_valid,
  output logic            busy
);

  localparam int RC_W = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ROUND,
    S_FINAL
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NB*8-1:0]   r_h;
  logic [NB*8-1:0]   r_cv;
  logic [NB*8-1:0]   r_iv;
  logic [NB*8-1:0]   r_digest;
  logic [RC_W-1:0]   r_rc;
  logic              r_last;
  logic              r_dv;

  logic [NB*8-1:0]   w_hRound;
  logic [NB*8-1:0]   w_cvNext;
  logic [NB*8-1:0]   w_digest;
  logic [7:0]        w_sum;
  logic [7:0]        w_rc8;
  logic              w_lastRound;

  assign w_rc8       = 8'(r_rc);
  assign w_lastRound = (r_rc == RC_W'(ROUNDS - 1));

  // One round: every byte is computed from the old H, so the update is fully parallel.
  always_comb begin
    w_hRound = '0;
    w_sum    = '0;
    for (int i = 0; i < NB; i++) begin
      w_sum = r_h[8*i +: 8] + r_h[8*((i+1)%NB) +: 8];
      w_hRound[8*i +: 8] = {w_sum[4:0], w_sum[7:5]} ^ r_iv[8*i +: 8] ^ w_rc8;
    end
  end

`ifdef HASH_FEEDFWD_EN
  assign w_cvNext = w_hRound ^ r_cv;
`else
  assign w_cvNext = w_hRound;
`endif

  always_comb begin
    w_digest = '0;
    for (int i = 0; i < NB; i++) begin
      w_digest[8*i +: 8] = r_cv[8*i +: 8] ^ r_iv[8*(NB-1-i) +: 8];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!abort && start) w_next = S_WAIT;
      S_WAIT: begin
        if (abort)          w_next = S_IDLE;
        else if (msg_valid) w_next = S_ROUND;
      end
      S_ROUND: begin
        if (abort)            w_next = S_IDLE;
        else if (w_lastRound) w_next = r_last ? S_FINAL : S_WAIT;
      end
      S_FINAL: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Abort leaves H/CV/digest untouched; only the state returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_h      <= '0;
      r_cv     <= '0;
      r_iv     <= '0;
      r_digest <= '0;
      r_rc     <= '0;
      r_last   <= 1'b0;
      r_dv     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dv    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_iv <= iv;
            r_cv <= iv;
          end
        end
        S_WAIT: begin
          if (msg_valid && !abort) begin
            r_h    <= r_cv ^ msg_data;
            r_last <= msg_last;
            r_rc   <= '0;
          end
        end
        S_ROUND: begin
          if (!abort) begin
            r_h  <= w_hRound;
            r_rc <= r_rc + RC_W'(1);
            if (w_lastRound) r_cv <= w_cvNext;
          end
        end
        S_FINAL: begin
          if (!abort) begin
            r_digest <= w_digest;
            r_dv     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign msg_ready    = (r_state == S_WAIT);
  assign busy         = (r_state != S_IDLE);
  assign digest       = r_digest;
  assign digest_valid = r_dv;

endmodule

// File: tb/tb_hash_stream.sv
// Directed bench for hash_stream: a 1-round instance with hand-computed digests and a 24-round
// instance checked against a byte-level reference of the hash.
module tb_hash_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        startA, validA, lastA, abortA, readyA, dvA, busyA;
  logic [31:0] ivA, dataA, digestA;
  logic        startB, validB, lastB, abortB, readyB, dvB, busyB;
  logic [31:0] ivB, dataB, digestB;

  int testCount = 0;
  int failCount = 0;
  int cycleNo   = 0;
  int pulseCntB = 0;

  hash_stream #(.NB(4), .ROUNDS(1)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .iv(ivA),
    .msg_valid(validA), .msg_ready(readyA), .msg_data(dataA), .msg_last(lastA),
    .abort(abortA), .digest(digestA), .digest_valid(dvA), .busy(busyA)
  );

  hash_stream #(.NB(4), .ROUNDS(24)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .iv(ivB),
    .msg_valid(validB), .msg_ready(readyB), .msg_data(dataB), .msg_last(lastB),
    .abort(abortB), .digest(digestB), .digest_valid(dvB), .busy(busyB)
  );

  always @(posedge clk) cycleNo++;
  always @(negedge clk) if (dvB) pulseCntB++;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference hash for NB=4, following the block/round/finalisation rules.
  function automatic logic [31:0] modelHash(input logic [31:0] ivv, input logic [31:0] b0,
                                            input logic [31:0] b1, input logic [31:0] b2,
                                            input int n, input int rounds);
    logic [7:0]  cv [4];
    logic [7:0]  h  [4];
    logic [7:0]  hn [4];
    logic [7:0]  ivb[4];
    logic [7:0]  s;
    logic [31:0] blk;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      ivb[i] = ivv[8*i +: 8];
      cv[i]  = ivb[i];
    end
    for (int b = 0; b < n; b++) begin
      blk = (b == 0) ? b0 : (b == 1) ? b1 : b2;
      for (int i = 0; i < 4; i++) h[i] = cv[i] ^ blk[8*i +: 8];
      for (int r = 0; r < rounds; r++) begin
        for (int i = 0; i < 4; i++) begin
          s     = h[i] + h[(i+1)%4];
          hn[i] = {s[4:0], s[7:5]} ^ ivb[i] ^ 8'(r);
        end
        for (int i = 0; i < 4; i++) h[i] = hn[i];
      end
`ifdef HASH_FEEDFWD_EN
      for (int i = 0; i < 4; i++) cv[i] = h[i] ^ cv[i];
`else
      for (int i = 0; i < 4; i++) cv[i] = h[i];
`endif
    end
    for (int i = 0; i < 4; i++) res[8*i +: 8] = cv[i] ^ ivb[3-i];
    return res;
  endfunction

  // Single-block message through the 1-round instance.
  task automatic applyStimulus(input logic [31:0] ivv, input logic [31:0] expDigest);
    ivA = ivv; startA = 1'b1;
    tick();
    startA = 1'b0;
    checkOutput("A_readyWait", readyA, 1);
    validA = 1'b1; dataA = 32'h04030201; lastA = 1'b1;
    tick();
    validA = 1'b0;
    checkOutput("A_readyRound", readyA, 0);
    checkOutput("A_dvEarly", dvA, 0);
    tick();
    checkOutput("A_dvEarly2", dvA, 0);
    tick();
    checkOutput("A_dv", dvA, 1);
    checkOutput("A_digest", digestA, expDigest);
    checkOutput("A_busyIdle", busyA, 0);
    tick();
    checkOutput("A_dvPulse", dvA, 0);
    checkOutput("A_digestHold", digestA, expDigest);
  endtask

  task automatic startMsgB(input logic [31:0] ivv);
    ivB = ivv; startB = 1'b1;
    tick();
    startB = 1'b0;
  endtask

  task automatic acceptB(input string tag, input logic [31:0] data, input logic last, output int acc);
    int n = 0;
    validB = 1'b1; dataB = data; lastB = last;
    while (!readyB && n < 100) begin
      tick();
      n++;
    end
    if (!readyB) checkOutput({tag, "_readyTimeout"}, readyB, 1);
    tick();
    acc = cycleNo;
  endtask

  task automatic sendBlockB(input string tag, input logic [31:0] data, input logic last, input int gap,
                            output int acc);
    int lowCount = 0;
    repeat (gap) tick();
    acceptB(tag, data, last, acc);
    validB = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!readyB) lowCount++;
      tick();
    end
    checkOutput({tag, "_readyLow"}, lowCount, 24);
    if (!last) checkOutput({tag, "_readyBack"}, readyB, 1);
  endtask

  task automatic waitDigestB(input string tag, input int acc, input logic [31:0] expDigest);
    int n = 0;
    int p0 = pulseCntB;
    while (!dvB && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, "_dv"}, dvB, 1);
    checkOutput({tag, "_latency"}, cycleNo - acc, 25);
    checkOutput({tag, "_digest"}, digestB, expDigest);
    repeat (5) tick();
    checkOutput({tag, "_pulses"}, pulseCntB - p0, 1);
    checkOutput({tag, "_busy"}, busyB, 0);
  endtask

  initial begin
    int acc;
    logic [31:0] expB;
    logic [31:0] lastDigestB;
    int p0;

    rst_n = 1'b0;
    startA = 0; ivA = 0; validA = 0; dataA = 0; lastA = 0; abortA = 0;
    startB = 0; ivB = 0; validB = 0; dataB = 0; lastB = 0; abortB = 0;
    #12;
    checkOutput("rst_busy", busyB, 0);
    checkOutput("rst_ready", readyB, 0);
    checkOutput("rst_dv", dvB, 0);
    checkOutput("rst_digest", digestB, 0);
    checkOutput("rst_busyA", busyA, 0);
    #5 rst_n = 1'b1;
    tick();

    applyStimulus(32'h00000000, 32'h28382818);
`ifdef HASH_FEEDFWD_EN
    applyStimulus(32'hFFFFFFFF, 32'h30403020);
`else
    applyStimulus(32'hFFFFFFFF, 32'hCFBFCFDF);
`endif

    // Three-block message with gaps 0 and 5 before blocks 2 and 3.
    expB = modelHash(32'h1234ABCD, 32'hDEADBEEF, 32'h01020304, 32'hA5A55A5A, 3, 24);
    startMsgB(32'h1234ABCD);
    checkOutput("B_busyWait", busyB, 1);
    sendBlockB("B3_blk0", 32'hDEADBEEF, 1'b0, 0, acc);
    sendBlockB("B3_blk1", 32'h01020304, 1'b0, 0, acc);
    sendBlockB("B3_blk2", 32'hA5A55A5A, 1'b1, 5, acc);
    waitDigestB("B3", acc, expB);

    // start and msg_valid held during ROUND must be ignored.
    expB = modelHash(32'h0F0F0F0F, 32'h11223344, 0, 0, 1, 24);
    startMsgB(32'h0F0F0F0F);
    acceptB("Bign", 32'h11223344, 1'b1, acc);
    repeat (5) tick();
    ivB = 32'hFFFF0000; startB = 1'b1;
    tick();
    startB = 1'b0;
    checkOutput("Bign_readyRound", readyB, 0);
    waitDigestB("Bign", acc, expB);
    validB = 1'b0;
    lastDigestB = expB;

    // Abort mid-ROUND of block 2, then a clean message.
    startMsgB(32'hCAFEF00D);
    sendBlockB("Bab_blk0", 32'h55AA55AA, 1'b0, 0, acc);
    acceptB("Bab_blk1", 32'h00FF00FF, 1'b0, acc);
    validB = 1'b0;
    repeat (10) tick();
    p0 = pulseCntB;
    abortB = 1'b1;
    tick();
    abortB = 1'b0;
    checkOutput("Bab_busy", busyB, 0);
    checkOutput("Bab_ready", readyB, 0);
    repeat (30) tick();
    checkOutput("Bab_noPulse", pulseCntB - p0, 0);
    checkOutput("Bab_digestHold", digestB, lastDigestB);
    expB = modelHash(32'h89ABCDEF, 32'h76543210, 0, 0, 1, 24);
    startMsgB(32'h89ABCDEF);
    sendBlockB("Bpost", 32'h76543210, 1'b1, 2, acc);
    waitDigestB("Bpost", acc, expB);

    // Asynchronous reset mid-ROUND.
    startMsgB(32'h13579BDF);
    acceptB("Brst", 32'h2468ACE0, 1'b1, acc);
    validB = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("Brst_busy", busyB, 0);
    checkOutput("Brst_ready", readyB, 0);
    checkOutput("Brst_dv", dvB, 0);
    checkOutput("Brst_digest", digestB, 0);
    #3 rst_n = 1'b1;
    tick();
    expB = modelHash(32'hFEDCBA98, 32'h0BADC0DE, 0, 0, 1, 24);
    startMsgB(32'hFEDCBA98);
    sendBlockB("BrstPost", 32'h0BADC0DE, 1'b1, 0, acc);
    waitDigestB("BrstPost", acc, expB);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
